// File: rtl/filter_pkg.sv
// Shared definitions for the filter chain blocks: FSM state encoding and
// accumulator width helper.
package filter_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } filt_state_e;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned log2_l);
    return data_width + log2_l;
  endfunction

endpackage

// File: rtl/lerp_datapath.sv
// Sample storage, slope and phase accumulator for the linear interpolator.
// LINEAR_INTERP_ROUND_EN selects round-half-up output instead of floor.
module lerp_datapath
  import filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned LOG2_L     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  prime,
  input  logic                  load,
  input  logic                  sel_cur,
  input  logic                  step,
  input  logic                  retire,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, LOG2_L);

  logic [DATA_WIDTH-1:0]   x_prev_q, x_prev_d;
  logic [DATA_WIDTH-1:0]   x_cur_q, x_cur_d;
  logic signed [DATA_WIDTH:0] diff_q, diff_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   base;

  always_comb begin
    x_prev_d = x_prev_q;
    x_cur_d  = x_cur_q;
    diff_d   = diff_q;
    acc_d    = acc_q;
    // A reload from RUN chains off the sample that just finished as x_cur.
    base     = sel_cur ? x_cur_q : x_prev_q;
    if (clr) begin
      x_prev_d = '0;
      x_cur_d  = '0;
      diff_d   = '0;
      acc_d    = '0;
    end else if (prime) begin
      x_prev_d = in_data;
    end else if (load) begin
      x_prev_d = base;
      x_cur_d  = in_data;
      diff_d   = {1'b0, in_data} - {1'b0, base};
      acc_d    = {base, {LOG2_L{1'b0}}};
    end else if (step) begin
      acc_d = acc_q + ACC_W'(diff_q);
    end else if (retire) begin
      x_prev_d = x_cur_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q <= '0;
      x_cur_q  <= '0;
      diff_q   <= '0;
      acc_q    <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      x_cur_q  <= x_cur_d;
      diff_q   <= diff_d;
      acc_q    <= acc_d;
    end
  end

`ifdef LINEAR_INTERP_ROUND_EN
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_L - 1);
  logic [ACC_W-1:0] acc_rnd;

  always_comb begin
    acc_rnd  = acc_q + HALF;
    out_data = DATA_WIDTH'(acc_rnd >> LOG2_L);
  end
`else
  always_comb begin
    out_data = DATA_WIDTH'(acc_q >> LOG2_L);
  end
`endif

endmodule

// File: rtl/linear_interp_upsampler.sv
// Linear-interpolation upsampler by L = 2**LOG2_L with valid/ready on both
// sides. Define LINEAR_INTERP_ROUND_EN for round-half-up output.
module linear_interp_upsampler
  import filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned LOG2_L     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [LOG2_L-1:0] K_LAST = '1;

  filt_state_e       state_q, state_d;
  logic [LOG2_L-1:0] k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic              last, in_hs, out_hs;
  logic              prime, load, sel_cur, step, retire;

  always_comb begin
    last     = (k_q == K_LAST);
    in_ready = (state_q != RUN) || (last && out_ready);
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid_q && out_ready;
    state_d  = state_q;
    k_d      = k_q;
    prime    = 1'b0;
    load     = 1'b0;
    sel_cur  = 1'b0;
    step     = 1'b0;
    retire   = 1'b0;
    if (clr) begin
      state_d = EMPTY;
      k_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            prime   = 1'b1;
            state_d = PRIMED;
          end
        end
        PRIMED: begin
          if (in_hs) begin
            load    = 1'b1;
            k_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (out_hs) begin
            if (!last) begin
              step = 1'b1;
              k_d  = k_q + 1'b1;
            end else if (in_hs) begin
              load    = 1'b1;
              sel_cur = 1'b1;
              k_d     = '0;
            end else begin
              retire  = 1'b1;
              state_d = PRIMED;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  lerp_datapath #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2_L    (LOG2_L)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .prime   (prime),
    .load    (load),
    .sel_cur (sel_cur),
    .step    (step),
    .retire  (retire),
    .in_data (in_data),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Scoreboard bench for linear_interp_upsampler (L=4, 24-bit); honours
// LINEAR_INTERP_ROUND_EN when computing expected outputs.
module tb_linear_interp_upsampler;

  localparam int unsigned DW  = 24;
  localparam int unsigned LG  = 2;
  localparam int unsigned L   = 1 << LG;

  logic          clk, rst_n, clr;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready;

  int unsigned   total, bad, cyc, n_out, ir_run;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] out_log[$];
  int unsigned   out_cyc[$];
  int unsigned   acc_cyc[$];
  logic          m_primed;
  longint        m_prev;

  linear_interp_upsampler #(
    .DATA_WIDTH(DW),
    .LOG2_L    (LG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard; inputs are stable from posedge+1 on.
  always @(negedge clk) begin
    logic [DW-1:0] exp_v;
    longint        a;
    if (!rst_n || clr) begin
      sb.delete();
      m_primed = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        out_cyc.push_back(cyc);
        n_out++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%0d required=none", out_data);
        end else begin
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            bad++;
            $display("FAIL sb_data got=%0d required=%0d", out_data, exp_v);
          end
        end
      end
      if (out_valid && in_ready) ir_run++;
      if (in_valid && in_ready) begin
        if (m_primed) begin
          for (int k = 0; k < int'(L); k++) begin
            a = m_prev * L + longint'(k) * (longint'(in_data) - m_prev);
`ifdef LINEAR_INTERP_ROUND_EN
            sb.push_back(DW'((a + L / 2) / L));
`else
            sb.push_back(DW'(a / L));
`endif
          end
        end
        m_prev   = longint'(in_data);
        m_primed = 1'b1;
      end
    end
  end

  task automatic send_stream();
    bit ok;
    acc_cyc.delete();
    while (stim_q.size() > 0) begin
      in_data  = stim_q[0];
      in_valid = 1'b1;
      ok = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL send_timeout data=%0d in_ready=%0b required=1", stim_q[0], in_ready);
      end
      acc_cyc.push_back(cyc);
      void'(stim_q.pop_front());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int w = 0; w < 60; w++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_log.delete();
    out_cyc.delete();
    ir_run = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b d=%0d r=%0b required v=0 d=0 r=1",
               out_valid, out_data, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    logic [DW-1:0] exp_v[8] = '{100, 125, 150, 175, 200, 150, 100, 50};
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{100, 200, 0};
    send_stream();
    wait_drain("ramp");
    total++;
    if (out_log.size() != 8) begin
      bad++;
      $display("FAIL ramp_count got=%0d required=8", out_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (out_log[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL ramp_value[%0d] got=%0d required=%0d", i, out_log[i], exp_v[i]);
        end
      end
      total++;
      if (out_cyc[7] - out_cyc[0] != 7) begin
        bad++;
        $display("FAIL ramp_bubbles span=%0d required=7", out_cyc[7] - out_cyc[0]);
      end
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[1] != L) begin
      bad++;
      $display("FAIL ramp_accept_gap got=%0d,%0d required=1,%0d",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], L);
    end
    total++;
    if (ir_run != 2) begin
      bad++;
      $display("FAIL ramp_in_ready_in_run got=%0d required=2", ir_run);
    end
  endtask

  task automatic test_small_step();
`ifdef LINEAR_INTERP_ROUND_EN
    logic [DW-1:0] exp_v[4] = '{0, 1, 2, 2};
`else
    logic [DW-1:0] exp_v[4] = '{0, 0, 1, 2};
`endif
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{0, 3};
    send_stream();
    wait_drain("small");
    total++;
    if (out_log.size() != 4) begin
      bad++;
      $display("FAIL small_count got=%0d required=4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (out_log[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL small_value[%0d] got=%0d required=%0d", i, out_log[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_v[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{10, 50, 90};
    fork
      send_stream();
      begin
        for (int w = 0; w < 50; w++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          total++;
          if (out_data !== 20 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold[%0d] got d=%0d r=%0b v=%0b required d=20 r=0 v=1",
                     i, out_data, in_ready, out_valid);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("bp");
    total++;
    if (out_log.size() != 8) begin
      bad++;
      $display("FAIL bp_count got=%0d required=8", out_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (out_log[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL bp_value[%0d] got=%0d required=%0d", i, out_log[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [DW-1:0] exp_v[8] = '{7, 8, 9, 10, 11, 12, 13, 14};
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{7, 11};
    send_stream();
    wait_drain("starve");
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || dut.state_q !== filter_pkg::PRIMED) begin
      bad++;
      $display("FAIL starve_idle got v=%0b state=%0d required v=0 state=1",
               out_valid, dut.state_q);
    end
    @(posedge clk); #1;
    stim_q = '{15};
    send_stream();
    wait_drain("resume");
    total++;
    if (out_log.size() != 8) begin
      bad++;
      $display("FAIL starve_count got=%0d required=8", out_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (out_log[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL starve_value[%0d] got=%0d required=%0d", i, out_log[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_clr_in_run();
    logic [DW-1:0] exp_v[4] = '{5, 6, 7, 8};
    int unsigned   n0;
    bit            ok;
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{40, 80};
    send_stream();
    in_data  = 120;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (in_ready && out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clr_final_phase in_ready=%0b required=1", in_ready);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_after got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
    end
    out_log.delete();
    n0 = n_out;
    stim_q = '{5};
    send_stream();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || n_out != n0) begin
      bad++;
      $display("FAIL clr_prime_only got v=%0b outs=%0d required v=0 outs=0",
               out_valid, n_out - n0);
    end
    stim_q = '{9};
    send_stream();
    wait_drain("clr");
    total++;
    if (out_log.size() != 4) begin
      bad++;
      $display("FAIL clr_count got=%0d required=4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (out_log[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL clr_value[%0d] got=%0d required=%0d", i, out_log[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int unsigned n0;
    pulse_clr();
    out_ready = 1'b1;
    stim_q = '{1000, 2000};
    send_stream();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_run got v=%0d d=%0d r=%0b required v=0 d=0 r=1",
               out_valid, out_data, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    stim_q = '{3000};
    send_stream();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || n_out != n0 || sb.size() != 0) begin
      bad++;
      $display("FAIL rst_first_sample got v=%0b outs=%0d required v=0 outs=0",
               out_valid, n_out - n0);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; clr = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    total = 0; bad = 0; cyc = 0; n_out = 0; ir_run = 0;
    m_primed = 1'b0; m_prev = 0;
    test_reset();
    test_ramp();
    test_small_step();
    test_backpressure();
    test_starvation();
    test_clr_in_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
